// File: rtl/wb_cmd_pkg.sv
// rtl/wb_cmd_pkg.sv - shared state encoding, status codes and header layout for wb_cmd_master
package wb_cmd_pkg;

   typedef enum logic [2:0] {
      ST_HDR  = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_REQ  = 3'd3,
      ST_WAIT = 3'd4,
      ST_RSP  = 3'd5
   } state_t;

   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

   localparam int HDR_WE_BIT  = 7;
   localparam int HDR_SEL_MSB = 3;
   localparam int HDR_SEL_LSB = 0;

   localparam logic [2:0] RSP_LAST_WR = 3'd0;
   localparam logic [2:0] RSP_LAST_RD = 3'd4;

   // Response byte idx: 0 is the status, 1..4 are the read data, least significant first.
   function automatic logic [7:0] rsp_byte(input logic [7:0]  status,
                                           input logic [31:0] data,
                                           input logic [2:0]  idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = status;
         3'd1:    b = data[7:0];
         3'd2:    b = data[15:8];
         3'd3:    b = data[23:16];
         3'd4:    b = data[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - byte-stream command to single Wishbone transaction bridge
// Optional WAIT timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
   import wb_cmd_pkg::*;
#(
   parameter int WB_ADDR_WIDTH  = 6,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [7:0]               i_cmd_data,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   output logic [7:0]               o_rsp_data,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_ack,
   output logic                     o_wb_we,
   output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
   output logic [31:0]              o_wb_data,
   output logic [3:0]               o_wb_sel,
   input  logic [31:0]              i_wb_data
);

   state_t                   state, state_n;
   logic [1:0]               byte_cnt, byte_cnt_n;
   logic [2:0]               rsp_idx, rsp_idx_n;
   logic [7:0]               status, status_n;
   logic [31:0]              rd_data, rd_data_n;
   logic                     cmd_ready_n, cyc_n, stb_n, rsp_valid_n;
   logic                     we_n;
   logic [WB_ADDR_WIDTH-1:0] addr_n;
   logic [31:0]              wr_data_n;
   logic [3:0]               sel_n;
   logic [7:0]               rsp_data_n;
   logic                     cmd_accept;
   logic                     rsp_last;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   logic [15:0] tmo_cnt, tmo_cnt_n;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

   assign cmd_accept = i_cmd_valid && o_cmd_ready;
   assign rsp_last   = (rsp_idx == (o_wb_we ? RSP_LAST_WR : RSP_LAST_RD));

   always_comb begin
      state_n    = state;
      byte_cnt_n = byte_cnt;
      rsp_idx_n  = rsp_idx;
      status_n   = status;
      rd_data_n  = rd_data;
      we_n       = o_wb_we;
      addr_n     = o_wb_addr;
      wr_data_n  = o_wb_data;
      sel_n      = o_wb_sel;
      rsp_data_n = o_rsp_data;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmo_cnt_n  = tmo_cnt;
`endif

      case (state)
         ST_HDR: begin
            if (cmd_accept) begin
               we_n    = i_cmd_data[HDR_WE_BIT];
               sel_n   = i_cmd_data[HDR_SEL_MSB:HDR_SEL_LSB];
               state_n = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (cmd_accept) begin
               addr_n     = i_cmd_data[WB_ADDR_WIDTH-1:0];
               byte_cnt_n = 2'd0;
               state_n    = o_wb_we ? ST_DATA : ST_REQ;
            end
         end
         ST_DATA: begin
            if (cmd_accept) begin
               wr_data_n[{byte_cnt, 3'b000} +: 8] = i_cmd_data;
               byte_cnt_n = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) state_n = ST_REQ;
            end
         end
         ST_REQ: begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_n = '0;
`endif
            if (!i_wb_stall) state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_wb_ack) begin
               status_n   = STATUS_OK;
               if (!o_wb_we) rd_data_n = i_wb_data;
               rsp_idx_n  = 3'd0;
               rsp_data_n = STATUS_OK;
               state_n    = ST_RSP;
            end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               status_n   = STATUS_TIMEOUT;
               rd_data_n  = 32'h0000_0000;
               rsp_idx_n  = 3'd0;
               rsp_data_n = STATUS_TIMEOUT;
               state_n    = ST_RSP;
            end else begin
               tmo_cnt_n = tmo_cnt + 16'd1;
            end
`endif
         end
         ST_RSP: begin
            if (i_rsp_ready) begin
               if (rsp_last) begin
                  state_n = ST_HDR;
               end else begin
                  rsp_idx_n  = rsp_idx + 3'd1;
                  rsp_data_n = rsp_byte(status, rd_data, rsp_idx + 3'd1);
               end
            end
         end
         default: state_n = ST_HDR;
      endcase

      // Handshake outputs are registered from the next state so reset holds them all low.
      cmd_ready_n = (state_n == ST_HDR) || (state_n == ST_ADDR) || (state_n == ST_DATA);
      cyc_n       = (state_n == ST_REQ) || (state_n == ST_WAIT);
      stb_n       = (state_n == ST_REQ);
      rsp_valid_n = (state_n == ST_RSP);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_HDR;
         byte_cnt    <= 2'd0;
         rsp_idx     <= 3'd0;
         status      <= STATUS_OK;
         rd_data     <= 32'h0000_0000;
         o_cmd_ready <= 1'b0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_addr   <= '0;
         o_wb_data   <= 32'h0000_0000;
         o_wb_sel    <= 4'h0;
         o_rsp_data  <= 8'h00;
      end else begin
         state       <= state_n;
         byte_cnt    <= byte_cnt_n;
         rsp_idx     <= rsp_idx_n;
         status      <= status_n;
         rd_data     <= rd_data_n;
         o_cmd_ready <= cmd_ready_n;
         o_wb_cyc    <= cyc_n;
         o_wb_stb    <= stb_n;
         o_rsp_valid <= rsp_valid_n;
         o_wb_we     <= we_n;
         o_wb_addr   <= addr_n;
         o_wb_data   <= wr_data_n;
         o_wb_sel    <= sel_n;
         o_rsp_data  <= rsp_data_n;
      end
   end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) tmo_cnt <= '0;
      else          tmo_cnt <= tmo_cnt_n;
   end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed plus randomized bench for wb_cmd_master with reactive Wishbone slave
module tb_wb_cmd_master;

   localparam int AW  = 6;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    cmd_data = 8'h00;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [7:0]    rsp_data;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          wb_cyc, wb_stb, wb_stall, wb_we;
   logic          wb_ack = 1'b0;
   logic [AW-1:0] wb_addr;
   logic [31:0]   wb_wdata, wb_rdata;
   logic [3:0]    wb_sel;

   int            stall_cfg = 0;
   bit            ack_en = 1'b1;
   logic [31:0]   slave_rdata = 32'h0;

   int            cycle = 0, stb_run = 0;
   int            stb_total = 0, wait_total = 0, ready_bad = 0, stab_bad = 0, txn_n = 0;
   logic          t_we [64];
   logic [AW-1:0] t_addr [64];
   logic [31:0]   t_data [64];
   logic [3:0]    t_sel [64];
   logic          prev_cyc = 1'b0;
   logic [AW+36:0] held_ctl = '0;

   int            total = 0, passed = 0;
   int            last_hs = 0;
   logic [7:0]    exp_q [$];

   wb_cmd_master #(.WB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_data(cmd_data), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .o_rsp_data(rsp_data), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
      .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
      .i_wb_data(wb_rdata)
   );

   always #5 clk = ~clk;

   assign wb_stall = wb_stb && (stb_run < stall_cfg);
   assign wb_rdata = wb_ack ? slave_rdata : 32'h0BAD_0BAD;

   always @(posedge clk) begin
      cycle   <= cycle + 1;
      stb_run <= wb_stb ? stb_run + 1 : 0;
      wb_ack  <= ack_en && wb_cyc && wb_stb && !wb_stall;
      if (wb_cyc && wb_stb && !wb_stall) begin
         t_we[txn_n % 64]   <= wb_we;
         t_addr[txn_n % 64] <= wb_addr;
         t_data[txn_n % 64] <= wb_wdata;
         t_sel[txn_n % 64]  <= wb_sel;
         txn_n <= txn_n + 1;
      end
      if (wb_stb) stb_total <= stb_total + 1;
      if (wb_cyc && !wb_stb) wait_total <= wait_total + 1;
      if (wb_cyc && cmd_ready) ready_bad <= ready_bad + 1;
      if (wb_cyc) begin
         if (prev_cyc && held_ctl != {wb_we, wb_addr, wb_wdata, wb_sel}) stab_bad <= stab_bad + 1;
         held_ctl <= {wb_we, wb_addr, wb_wdata, wb_sel};
      end
      prev_cyc <= wb_cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      last_hs   = cycle;
      cmd_valid = 1'b0;
   endtask

   // mode 0: always ready, 1: random ready, 2: ready held low for 5 valid cycles first
   task automatic get_rsp(input int mode, input bit check_lat);
      int  i = 0, guard = 0, low = 0;
      bit  first = 1'b1, holding = 1'b0;
      logic [7:0] held = 8'h00;
      while (i < exp_q.size() && guard < 500) begin
         if (mode == 0)      rsp_ready = 1'b1;
         else if (mode == 1) rsp_ready = ($urandom_range(0, 1) == 1);
         else                rsp_ready = (low >= 5);
         if (rsp_valid) begin
            if (first) begin
               first = 1'b0;
               if (check_lat) chk("latency_edges", cycle - last_hs + 1, 32'd3);
            end
            if (holding) chk("rsp_hold", {24'b0, rsp_data}, {24'b0, held});
            if (rsp_ready) begin
               chk("rsp_byte", {24'b0, rsp_data}, {24'b0, exp_q[i]});
               i++;
               holding = 1'b0;
            end else begin
               holding = 1'b1;
               held    = rsp_data;
               low++;
            end
         end
         @(posedge clk); #1; guard++;
      end
      rsp_ready = 1'b0;
      if (guard >= 500) chk("rsp_timeout", i, exp_q.size());
      chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
      chk("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
   endtask

   task automatic run_cmd(input bit we, input logic [3:0] sel, input logic [2:0] junk,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int stall, input int mode);
      int stb0 = stb_total, wt0 = wait_total, rb0 = ready_bad, sb0 = stab_bad, tn0 = txn_n;
      stall_cfg   = stall;
      slave_rdata = rdata;
      ack_en      = 1'b1;
      send_byte({we, junk, sel});
      send_byte(addr);
      if (we) for (int k = 0; k < 4; k++) send_byte(8'((wdata >> (8 * k)) & 32'hFF));
      exp_q.delete();
      exp_q.push_back(8'h00);
      if (!we) for (int k = 0; k < 4; k++) exp_q.push_back(8'((rdata >> (8 * k)) & 32'hFF));
      get_rsp(mode, stall == 0);
      chk("txn_count", txn_n - tn0, 32'd1);
      if (txn_n > tn0) begin
         chk("txn_we", {31'b0, t_we[tn0 % 64]}, {31'b0, we});
         chk("txn_addr", 32'(t_addr[tn0 % 64]), 32'(int'(addr) % (1 << AW)));
         chk("txn_sel", {28'b0, t_sel[tn0 % 64]}, {28'b0, sel});
         if (we) chk("txn_data", t_data[tn0 % 64], wdata);
      end
      chk("stb_cycles", stb_total - stb0, stall + 1);
      chk("wait_cycles", wait_total - wt0, 32'd1);
      chk("ready_in_cyc", ready_bad - rb0, 32'd0);
      chk("wb_stable", stab_bad - sb0, 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
      chk("rst_stb", {31'b0, wb_stb}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_we", {31'b0, wb_we}, 32'd0);
      chk("rst_addr", 32'(wb_addr), 32'd0);
      chk("rst_wdata", wb_wdata, 32'd0);
      chk("rst_sel", {28'b0, wb_sel}, 32'd0);
      chk("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("cmd_ready_pre_edge", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      chk("cmd_ready_post_release", {31'b0, cmd_ready}, 32'd1);

      run_cmd(1'b1, 4'hF, 3'b000, 8'h05, 32'h1234_5678, 32'h0, 0, 0);
      run_cmd(1'b0, 4'h0, 3'b000, 8'h05, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_cmd(1'b1, 4'h3, 3'b101, 8'hC9, 32'hCAFE_F00D, 32'h0, 3, 0);
      run_cmd(1'b0, 4'hA, 3'b010, 8'h3F, 32'h0, 32'hA5C3_1E77, 0, 2);

      for (int i = 0; i < 24; i++) begin
         bit          we   = 1'($urandom_range(0, 1));
         logic [3:0]  sel  = (i % 6 == 0) ? 4'h0 : 4'($urandom);
         logic [2:0]  junk = 3'($urandom);
         logic [7:0]  addr = 8'($urandom);
         logic [31:0] wd   = $urandom;
         logic [31:0] rd   = $urandom;
         run_cmd(we, sel, junk, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 1));
      end

      ack_en    = 1'b0;
      stall_cfg = 0;
      send_byte(8'h00);
      send_byte(8'h05);
      n = 0;
      while (!(wb_cyc && !wb_stb) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("reached_wait", {31'b0, wb_cyc && !wb_stb}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cyc", {31'b0, wb_cyc}, 32'd0);
      chk("async_rst_stb", {31'b0, wb_stb}, 32'd0);
      chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("async_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_rsp_after_reset", {31'b0, rsp_valid}, 32'd0);
      run_cmd(1'b0, 4'h5, 3'b000, 8'h21, 32'h0, 32'h0F1E_2D3C, 0, 0);
      run_cmd(1'b1, 4'hC, 3'b111, 8'h7E, 32'h8765_4321, 32'h0, 1, 1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
      begin
         int wt0 = wait_total, tn0 = txn_n;
         ack_en    = 1'b0;
         stall_cfg = 0;
         send_byte(8'h00);
         send_byte(8'h05);
         exp_q.delete();
         exp_q.push_back(8'h01);
         for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
         get_rsp(0, 1'b0);
         chk("tmo_wait_cycles", wait_total - wt0, TMO);
         chk("tmo_txn_count", txn_n - tn0, 32'd1);
         ack_en = 1'b1;
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 6: width of the Wishbone word address; legal range 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for ack; legal range 1..65535.
REQ-003 SHALL have port i_clk, input, 1: clock, posedge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports i_cmd_data (input, 8), i_cmd_valid (input, 1), o_cmd_ready (output, 1): command byte stream in.
REQ-006 SHALL have ports o_rsp_data (output, 8), o_rsp_valid (output, 1), i_rsp_ready (input, 1): response byte stream out.
REQ-007 SHALL have Wishbone master ports: o_wb_cyc (1), o_wb_stb (1), i_wb_stall (1), i_wb_ack (1), o_wb_we (1), o_wb_addr (WB_ADDR_WIDTH), o_wb_data (32), o_wb_sel (4), i_wb_data (32).

Function
REQ-008 SHALL accept a byte when i_cmd_valid && o_cmd_ready; o_cmd_ready high only in HDR, ADDR and DATA states.
REQ-009 SHALL interpret the header byte as follows: bit7 = we; bits3:0 = sel; bits6:4 ignored.
REQ-010 SHALL take the next byte as the address; o_wb_addr = its low WB_ADDR_WIDTH bits.
REQ-011 SHALL, for writes, take 4 further bytes as data, little-endian (first byte -> o_wb_data[7:0]); reads have no data bytes.
REQ-012 SHALL use states HDR -> ADDR -> DATA (writes only, 2-bit byte counter 0..3) -> REQ -> WAIT -> RSP -> HDR.
REQ-013 SHALL assert o_wb_cyc and o_wb_stb together in REQ; on the first edge with !i_wb_stall it drops stb, keeps cyc, and enters WAIT.
REQ-014 SHALL, in WAIT, on i_wb_ack drop cyc, latch i_wb_data (reads only), set status 0x00, and enter RSP; ack seen in the REQ accept cycle is not valid.
REQ-015 SHALL hold o_wb_we, o_wb_addr, o_wb_data and o_wb_sel stable for the whole cycle; exactly one transaction is issued per command.
REQ-016 SHALL emit responses as follows: write -> 1 byte (status); read -> 5 bytes (status, then data LE, bits 7:0 first).
REQ-017 SHALL drive o_rsp_valid only in RSP; hold o_rsp_data stable until i_rsp_ready; advance one byte per handshake; return to HDR after the last byte.
REQ-018 SHALL NOT accept command bytes while in REQ, WAIT or RSP (backpressure only, no dropping).
REQ-019 SHALL give a minimum latency from the last command byte to the first o_rsp_valid of 3 cycles with zero stall and ack on the first WAIT cycle.
REQ-020 SHALL, for sel = 0, still issue the transaction.

Reset
REQ-021 SHALL, on i_rst_n low (async assert, sync deassert handled externally), force state HDR, byte counter 0, and o_wb_cyc, o_wb_stb, o_rsp_valid and o_cmd_ready to 0 immediately.
REQ-022 SHALL reset o_wb_we, o_wb_addr, o_wb_data, o_wb_sel and o_rsp_data to 0; o_cmd_ready rises on the first clock after release.
REQ-023 SHALL, on reset mid-transaction, abandon the transaction with no response; a partially received command is discarded.

Configuration
REQ-024 SHALL, with WB_CMD_MASTER_TIMEOUT_EN defined, count cycles in WAIT; on reaching TIMEOUT_CYCLES without ack, drop cyc, set status 0x01, set read data 0x00000000, and enter RSP.
REQ-025 SHALL, without WB_CMD_MASTER_TIMEOUT_EN, wait indefinitely in WAIT; status is always 0x00 and no counter is synthesised.

Structure
REQ-026 SHALL place state encoding, STATUS_OK = 8'h00, STATUS_TIMEOUT = 8'h01 and header bit positions in package wb_cmd_pkg.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 SHALL pass: stream 0x8F,0x05,0x78,0x56,0x34,0x12 -> one WB write addr 5, data 0x12345678, sel 0xF; response 0x00.
REQ-029 SHALL pass: with slave returning 0xDEADBEEF for read 0x00,0x05 -> response 0x00,0xEF,0xBE,0xAD,0xDE.
REQ-030 SHALL pass: i_wb_stall held 3 cycles -> stb high 4 cycles, single acknowledged transaction, o_cmd_ready low throughout.
REQ-031 SHALL pass: i_rsp_ready low 5 cycles during a read response -> o_rsp_data stable; no bytes lost or duplicated.
REQ-032 SHALL pass: with WB_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never given for a read -> cyc drops after 4 WAIT cycles; response 0x01,0x00,0x00,0x00,0x00.
REQ-033 SHALL pass: i_rst_n pulsed low during WAIT -> cyc/stb low asynchronously; the next full command executes normally.
